palette_stream_ctrl: RTL

- Sequences Mandelbrot iteration results into the combinational palette stage, one pixel per display-timing strobe.
- Buffers results from the compute engine in a small FIFO and emits the palette input byte: bit 7 = valid, bits 6:0 = index.
- Keeps frames aligned and latches B&W/colour mode only at frame boundaries.
- Sits between the iteration engine and the palette/VGA output.

---
 rtl/palette_stream_ctrl_if.sv | 15 +
 rtl/palette_stream_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/palette_stream_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | palette_stream_ctrl_if : iteration-result valid/ready stream    |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
interface palette_stream_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_iter;
  logic       in_sof;

  modport master (output in_valid, output in_iter, output in_sof, input  in_ready);
  modport slave  (input  in_valid, input  in_iter, input  in_sof, output in_ready);
endinterface
`default_nettype wire

// File: rtl/palette_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | palette_stream_ctrl : FIFO + frame-aligned pixel sequencer that |
// | feeds {valid, index} to the palette. Option: PAL_TESTPAT_EN     |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module palette_stream_ctrl #(
  parameter int DEPTH     = 16,
  parameter int FRAME_PIX = 307200,
  parameter int IDX_MAX   = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  palette_stream_ctrl_if.slave s_in,
  input  logic                 pix_en,
  input  logic                 frame_start,
  input  logic                 mode_req,
`ifdef PAL_TESTPAT_EN
  input  logic                 tp_en,
`endif
  output logic [7:0]           pal_din,
  output logic                 pal_mode,
  output logic [15:0]          underflow_cnt,
  output logic [15:0]          align_err_cnt,
  output logic [1:0]           dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(FRAME_PIX);
  localparam logic [PTR_W:0]   DEPTH_C     = (PTR_W + 1)'(DEPTH);
  localparam logic [7:0]       IDX_SAT     = 8'(IDX_MAX);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, pix_cnt_inc;
  logic [7:0]       pal_din_q, pal_din_d;
  logic             pal_mode_q, pal_mode_d;
  logic [15:0]      under_q, under_d;
  logic [15:0]      align_q, align_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       mem_q [DEPTH];

  logic       ready, push, pop, fifo_empty, head_sof, emit_adv;
  logic [6:0] head_idx, sat_idx;
  logic [7:0] head;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Readiness uses the registered count only, so a full FIFO never accepts
  // a write even when the same cycle pops.
  always_comb begin
    ready = ~rst & (count_q < DEPTH_C);
`ifdef PAL_TESTPAT_EN
    ready = ready & ~tp_en;
`endif
  end

  assign s_in.in_ready = ready;
  assign push          = s_in.in_valid & ready;
  assign sat_idx       = (s_in.in_iter > IDX_SAT) ? IDX_SAT[6:0] : s_in.in_iter[6:0];
  assign fifo_empty    = (count_q == '0);
  assign head          = mem_q[rd_ptr_q];
  assign head_sof      = head[7];
  assign head_idx      = head[6:0];
  assign pix_cnt_inc   = pix_cnt_q + 1'b1;

`ifdef PAL_TESTPAT_EN
  logic       tp_q, tp_d;
  logic [4:0] tp_idx;
  assign tp_d   = tp_en;
  assign tp_idx = 5'(pix_cnt_q);
`endif

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    pal_din_d  = 8'h00;
    pal_mode_d = frame_start ? mode_req : pal_mode_q;
    under_d    = under_q;
    align_d    = align_q;
    pop        = 1'b0;
    emit_adv   = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (frame_start && !fifo_empty) begin
          if (head_sof) begin
            state_d   = RUN;
            pix_cnt_d = '0;
          end else begin
            state_d   = RESYNC;
          end
        end
      end
      RUN: begin
        if (frame_start) begin
          align_d = sat_inc(align_q);
          state_d = RESYNC;
        end else if (pix_en) begin
          if (fifo_empty) begin
            under_d  = sat_inc(under_q);
            emit_adv = 1'b1;
          end else if (head_sof && pix_cnt_q != '0) begin
            align_d = sat_inc(align_q);
            state_d = RESYNC;
          end else begin
            pop       = 1'b1;
            pal_din_d = {1'b1, head_idx};
            emit_adv  = 1'b1;
          end
          if (emit_adv) begin
            pix_cnt_d = pix_cnt_inc;
            if (pix_cnt_inc == FRAME_PIX_C) state_d = SYNC;
          end
        end
      end
      RESYNC: begin
        if (!fifo_empty) begin
          if (head_sof) state_d = SYNC;
          else          pop     = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
`ifdef PAL_TESTPAT_EN
    // The pattern overrides the stream entirely; the FIFO is left intact.
    if (tp_en || tp_q) begin
      pop       = 1'b0;
      pal_din_d = 8'h00;
      pix_cnt_d = pix_cnt_q;
      under_d   = under_q;
      align_d   = align_q;
      state_d   = tp_en ? RUN : RESYNC;
      if (tp_en && pix_en) begin
        pal_din_d = {3'b100, tp_idx};
        pix_cnt_d = (pix_cnt_inc == FRAME_PIX_C) ? '0 : pix_cnt_inc;
      end
    end
`endif
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_in.in_sof, sat_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SYNC;
      pix_cnt_q  <= '0;
      pal_din_q  <= 8'h00;
      pal_mode_q <= 1'b0;
      under_q    <= 16'h0000;
      align_q    <= 16'h0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef PAL_TESTPAT_EN
      tp_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      pal_din_q  <= pal_din_d;
      pal_mode_q <= pal_mode_d;
      under_q    <= under_d;
      align_q    <= align_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef PAL_TESTPAT_EN
      tp_q       <= tp_d;
`endif
    end
  end

  assign pal_din       = pal_din_q;
  assign pal_mode      = pal_mode_q;
  assign underflow_cnt = under_q;
  assign align_err_cnt = align_q;
  assign dbg_state     = state_q;

endmodule
`default_nettype wire
